vga_avalon_fill: RTL

VGA_AVALON_FILL -- requirements
Module: vga_avalon_fill

---
 rtl/vga_avalon_fill.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_avalon_fill.sv
// Avalon-MM slave that queues single-pixel plots and generates clipped rectangle
// fills, streaming one registered pixel per cycle to a VGA adapter.
module vga_avalon_fill #(
    parameter int unsigned H_RES        = 160,
    parameter int unsigned V_RES        = 120,
    parameter int unsigned X_WIDTH      = 8,
    parameter int unsigned Y_WIDTH      = 7,
    parameter int unsigned COLOUR_WIDTH = 3,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              address,
    input  logic                    write,
    input  logic                    read,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic                    waitrequest,
    output logic [X_WIDTH-1:0]      plot_x,
    output logic [Y_WIDTH-1:0]      plot_y,
    output logic [COLOUR_WIDTH-1:0] plot_colour,
    output logic                    plot
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned XE_W  = X_WIDTH + 1;
    localparam int unsigned YE_W  = Y_WIDTH + 1;
    localparam logic [XE_W-1:0] H_LIM = XE_W'(H_RES);
    localparam logic [YE_W-1:0] V_LIM = YE_W'(V_RES);

    typedef struct packed {
        logic [X_WIDTH-1:0]      x;
        logic [Y_WIDTH-1:0]      y;
        logic [COLOUR_WIDTH-1:0] c;
    } pix_t;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state_q, state_d;
    pix_t                    mem_q [FIFO_DEPTH];
    pix_t                    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              drop_q, drop_d;
    logic [X_WIDTH-1:0]      x0_q, x0_d, cur_x_q, cur_x_d, x_start_q, x_start_d;
    logic [Y_WIDTH-1:0]      y0_q, y0_d, cur_y_q, cur_y_d;
    logic [XE_W-1:0]         x_end_q, x_end_d;
    logic [YE_W-1:0]         y_end_q, y_end_d;
    logic [COLOUR_WIDTH-1:0] fill_c_q, fill_c_d;
    logic                    plot_q, plot_d;
    logic [X_WIDTH-1:0]      plot_x_q, plot_x_d;
    logic [Y_WIDTH-1:0]      plot_y_q, plot_y_d;
    logic [COLOUR_WIDTH-1:0] plot_c_q, plot_c_d;

    logic [X_WIDTH-1:0]      wr_x;
    logic [Y_WIDTH-1:0]      wr_y;
    logic [COLOUR_WIDTH-1:0] wr_c;
    logic                    fifo_full, fifo_empty, is_plot, is_fill, wait_c;
    logic                    accept, in_range, push, pop, start, busy;
    logic [X_WIDTH-1:0]      fx0;
    logic [Y_WIDTH-1:0]      fy0;
    logic [XE_W-1:0]         fxe, sum_x;
    logic [YE_W-1:0]         fye, sum_y;
    logic                    unused_in;

    assign wr_x      = writedata[8 +: X_WIDTH];
    assign wr_y      = writedata[0 +: Y_WIDTH];
    assign wr_c      = writedata[16 +: COLOUR_WIDTH];
    assign unused_in = ^{read, writedata};

    // Command decode, FIFO bookkeeping, fill walker and pixel output selection
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        drop_d    = drop_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        x_start_d = x_start_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        fill_c_d  = fill_c_q;
        plot_d    = 1'b0;
        plot_x_d  = plot_x_q;
        plot_y_d  = plot_y_q;
        plot_c_d  = plot_c_q;

        fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (cnt_q == '0);
        is_plot    = write && (address == 4'd0);
        is_fill    = write && ((address == 4'd2) || (address == 4'd3));
        wait_c     = !reset && ((is_plot && fifo_full) ||
                                (is_fill && ((state_q == FILL) || !fifo_empty)));
        accept     = write && !wait_c;
        in_range   = ({1'b0, wr_x} < H_LIM) && ({1'b0, wr_y} < V_LIM);
        push       = accept && is_plot && in_range;
        pop        = (state_q == IDLE) && !fifo_empty;

        // Clip against the screen at one extra bit so x0+w cannot wrap
        sum_x = {1'b0, x0_q} + {1'b0, wr_x};
        sum_y = {1'b0, y0_q} + {1'b0, wr_y};
        if (address == 4'd3) begin
            fx0 = '0;
            fy0 = '0;
            fxe = H_LIM;
            fye = V_LIM;
        end else begin
            fx0 = x0_q;
            fy0 = y0_q;
            fxe = (sum_x < H_LIM) ? sum_x : H_LIM;
            fye = (sum_y < V_LIM) ? sum_y : V_LIM;
        end
        start = accept && is_fill && ({1'b0, fx0} < fxe) && ({1'b0, fy0} < fye);

        if (state_q == FILL) begin
            plot_d   = 1'b1;
            plot_x_d = cur_x_q;
            plot_y_d = cur_y_q;
            plot_c_d = fill_c_q;
            if (({1'b0, cur_x_q} + XE_W'(1)) == x_end_q) begin
                cur_x_d = x_start_q;
                cur_y_d = cur_y_q + Y_WIDTH'(1);
                if (({1'b0, cur_y_q} + YE_W'(1)) == y_end_q) begin
                    state_d = IDLE;
                end
            end else begin
                cur_x_d = cur_x_q + X_WIDTH'(1);
            end
        end else if (pop) begin
            plot_d   = 1'b1;
            plot_x_d = mem_q[rd_ptr_q].x;
            plot_y_d = mem_q[rd_ptr_q].y;
            plot_c_d = mem_q[rd_ptr_q].c;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (start) begin
            state_d   = FILL;
            cur_x_d   = fx0;
            cur_y_d   = fy0;
            x_start_d = fx0;
            x_end_d   = fxe;
            y_end_d   = fye;
            fill_c_d  = wr_c;
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{x: wr_x, y: wr_y, c: wr_c};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (accept && (address == 4'd1)) begin
            x0_d = wr_x;
            y0_d = wr_y;
        end

        // Clear wins over a same-cycle drop
        if (accept && (address == 4'd4)) begin
            drop_d = '0;
        end else if (accept && is_plot && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign busy = (state_q == FILL) || (cnt_q != '0);

    always_comb begin
        readdata = '0;
        if (address == 4'd4) begin
            readdata = {16'b0, drop_q, 3'b0, 4'(cnt_q), busy};
        end
    end

    assign waitrequest = wait_c;
    assign plot        = plot_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = plot_c_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            fill_c_q  <= '0;
            plot_q    <= 1'b0;
            plot_x_q  <= '0;
            plot_y_q  <= '0;
            plot_c_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            x_start_q <= x_start_d;
            x_end_q   <= x_end_d;
            y_end_q   <= y_end_d;
            fill_c_q  <= fill_c_d;
            plot_q    <= plot_d;
            plot_x_q  <= plot_x_d;
            plot_y_q  <= plot_y_d;
            plot_c_q  <= plot_c_d;
        end
    end

    // FIFO storage needs no reset; the pointers define validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
